// File: rtl/sync_fifo_param_pkg.sv
// Shared definitions for the parametrised sample FIFO: read-mode encoding and
// a ceil(log2) helper for callers sizing AWIDTH from a required depth.
package sync_fifo_param_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res++;
            v = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_param_ram.sv
// Simple dual-port RAM for the sample FIFO: one write port, one read port that
// is either registered under a read enable or asynchronous (FWFT use).
module fifo_ram
    import sync_fifo_param_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int AWIDTH    = 2,
    parameter int SYNC_READ = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    (* ram_block *) logic [WIDTH-1:0] mem [2**AWIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync
            // Output register is reset so read_data starts at zero; the array is not.
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    rdata <= '0;
                end else if (re) begin
                    rdata <= mem[raddr];
                end
            end
        end else begin : g_async
            logic unused_ctrl;
            assign unused_ctrl = re ^ resetn;

            always_comb begin
                rdata = mem[raddr];
            end
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO between the S/PDIF decoder and I2S serialiser:
// extra-bit pointers, registered status flags, sticky errors, synchronous flush.
module sync_fifo_param
    import sync_fifo_param_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int AWIDTH       = 2,
    parameter int AFULL_LEVEL  = 3,
    parameter int AEMPTY_LEVEL = 1,
    parameter int FWFT         = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              write,
    input  logic [WIDTH-1:0]  write_data,
    input  logic              read,
    output logic [WIDTH-1:0]  read_data,
    output logic              read_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int            DEPTH    = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_L  = (AWIDTH+1)'(DEPTH);
    localparam logic [AWIDTH:0] AFULL_L  = (AWIDTH+1)'(AFULL_LEVEL);
    localparam logic [AWIDTH:0] AEMPTY_L = (AWIDTH+1)'(AEMPTY_LEVEL);
    localparam bit            IS_FWFT  = (FWFT == int'(FIFO_MODE_FWFT));

    generate
        if (AWIDTH < 1 || AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH ||
            AEMPTY_LEVEL < 0 || AEMPTY_LEVEL >= DEPTH) begin : g_bad_params
            $fatal(1, "sync_fifo_param: illegal AWIDTH/AFULL_LEVEL/AEMPTY_LEVEL");
        end
    endgenerate

    logic [AWIDTH:0] head_q, tail_q, level_q, level_n;
    logic            empty_q, full_q, afull_q, aempty_q;
    logic            ovf_q, unf_q, rvalid_q;
    logic            rd_acc, wr_acc;

    // Acceptance uses only registered flags, keeping read/write off the flag paths.
    always_comb begin
        rd_acc  = read & ~empty_q;
        wr_acc  = write & (~full_q | rd_acc);
        level_n = level_q + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q   <= '0;
            tail_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else if (clear) begin
            head_q   <= '0;
            tail_q   <= '0;
            level_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                head_q <= head_q + 1'b1;
            end
            if (rd_acc) begin
                tail_q <= tail_q + 1'b1;
            end
            level_q  <= level_n;
            empty_q  <= (level_n == '0);
            full_q   <= (level_n == DEPTH_L);
            afull_q  <= (level_n >= AFULL_L);
            aempty_q <= (level_n <= AEMPTY_L);
            ovf_q    <= ovf_q | (write & ~wr_acc);
            unf_q    <= unf_q | (read & ~rd_acc);
            rvalid_q <= rd_acc;
        end
    end

    fifo_ram #(
        .WIDTH     (WIDTH),
        .AWIDTH    (AWIDTH),
        .SYNC_READ (IS_FWFT ? 0 : 1)
    ) u_ram (
        .clk    (clk),
        .resetn (resetn),
        .we     (wr_acc & ~clear),
        .waddr  (head_q[AWIDTH-1:0]),
        .wdata  (write_data),
        .re     (rd_acc & ~clear),
        .raddr  (tail_q[AWIDTH-1:0]),
        .rdata  (read_data)
    );

    assign read_valid   = IS_FWFT ? ~empty_q : rvalid_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: standard and FWFT instances share one stimulus stream and
// are compared against a queue-based reference model plus a directed vector table.
module tb_sync_fifo_param;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear, write, read;
    logic [15:0] wdata;

    logic [15:0] s_rdata, f_rdata;
    logic        s_rv, s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
    logic        f_rv, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
    logic [2:0]  s_level, f_level;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [15:0] mq[$];
    bit          m_ovf, m_unf, m_rv;
    logic [15:0] m_rdata;

    typedef struct {
        bit          clr;
        bit          wr;
        logic [15:0] wd;
        bit          rd;
        int          lvl;
        logic [15:0] rdata;
        bit          rv, full, empty, af, ae, ovf, unf;
    } vec_t;

    vec_t tbl[15];

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH(16), .AWIDTH(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(0)
    ) dut_std (
        .clk(clk), .resetn(resetn), .clear(clear), .write(write), .write_data(wdata),
        .read(read), .read_data(s_rdata), .read_valid(s_rv), .empty(s_empty),
        .full(s_full), .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(
        .WIDTH(16), .AWIDTH(2), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .resetn(resetn), .clear(clear), .write(write), .write_data(wdata),
        .read(read), .read_data(f_rdata), .read_valid(f_rv), .empty(f_empty),
        .full(f_full), .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rv    = 1'b0;
        m_rdata = 16'h0000;
    endtask

    task automatic model_update(input bit c, input bit w, input logic [15:0] d, input bit r);
        bit rd_ok, wr_ok;
        if (c) begin
            mq.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv  = 1'b0;
        end else begin
            rd_ok = r && (mq.size() > 0);
            wr_ok = w && ((mq.size() < DEPTH) || rd_ok);
            if (w && !wr_ok) m_ovf = 1'b1;
            if (r && !rd_ok) m_unf = 1'b1;
            m_rv = rd_ok;
            if (rd_ok) m_rdata = mq.pop_front();
            if (wr_ok) mq.push_back(d);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("std_level", 32'(s_level), 32'(n));
        chk("std_empty", 32'(s_empty), 32'(n == 0));
        chk("std_full",  32'(s_full),  32'(n == DEPTH));
        chk("std_afull", 32'(s_af),    32'(n >= 3));
        chk("std_aempty",32'(s_ae),    32'(n <= 1));
        chk("std_ovf",   32'(s_ovf),   32'(m_ovf));
        chk("std_unf",   32'(s_unf),   32'(m_unf));
        chk("std_rvalid",32'(s_rv),    32'(m_rv));
        chk("std_rdata", 32'(s_rdata), 32'(m_rdata));
        chk("fw_level",  32'(f_level), 32'(n));
        chk("fw_full",   32'(f_full),  32'(n == DEPTH));
        chk("fw_afull",  32'(f_af),    32'(n >= 3));
        chk("fw_aempty", 32'(f_ae),    32'(n <= 1));
        chk("fw_ovf",    32'(f_ovf),   32'(m_ovf));
        chk("fw_unf",    32'(f_unf),   32'(m_unf));
        chk("fw_rvalid", 32'(f_rv),    32'(n != 0));
        if (n != 0) chk("fw_rdata", 32'(f_rdata), 32'(mq[0]));
    endtask

    task automatic step(input bit c, input bit w, input logic [15:0] d, input bit r);
        clear = c;
        write = w;
        wdata = d;
        read  = r;
        @(posedge clk);
        model_update(c, w, d, r);
        #1;
        check_all();
        clear = 1'b0;
        write = 1'b0;
        read  = 1'b0;
    endtask

    initial begin
        //         clr wr wd        rd   lvl rdata     rv full emp af ae ovf unf
        tbl[0]  = '{0, 1, 16'h0001, 0,   1, 16'h0000, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{0, 1, 16'h0002, 0,   2, 16'h0000, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 16'h0003, 0,   3, 16'h0000, 0, 0, 0, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 16'h0004, 0,   4, 16'h0000, 0, 1, 0, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 16'hDEAD, 0,   4, 16'h0000, 0, 1, 0, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 16'h0000, 0,   4, 16'h0000, 0, 1, 0, 1, 0, 1, 0};
        tbl[6]  = '{0, 1, 16'h0005, 1,   4, 16'h0001, 1, 1, 0, 1, 0, 1, 0};
        tbl[7]  = '{0, 0, 16'h0000, 1,   3, 16'h0002, 1, 0, 0, 1, 0, 1, 0};
        tbl[8]  = '{0, 0, 16'h0000, 1,   2, 16'h0003, 1, 0, 0, 0, 0, 1, 0};
        tbl[9]  = '{0, 0, 16'h0000, 1,   1, 16'h0004, 1, 0, 0, 0, 1, 1, 0};
        tbl[10] = '{0, 0, 16'h0000, 1,   0, 16'h0005, 1, 0, 1, 0, 1, 1, 0};
        tbl[11] = '{0, 0, 16'h0000, 0,   0, 16'h0005, 0, 0, 1, 0, 1, 1, 0};
        tbl[12] = '{0, 1, 16'h0007, 1,   1, 16'h0005, 0, 0, 0, 0, 1, 1, 1};
        tbl[13] = '{1, 1, 16'h0009, 1,   0, 16'h0005, 0, 0, 1, 0, 1, 0, 0};
        tbl[14] = '{0, 0, 16'h0000, 0,   0, 16'h0005, 0, 0, 1, 0, 1, 0, 0};

        resetn = 1'b0;
        clear  = 1'b0;
        write  = 1'b0;
        read   = 1'b0;
        wdata  = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_fw_empty", 32'(f_empty), 32'd1);
        resetn = 1'b1;

        // directed fill/drain, overflow, boundary read+write, clear
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd);
            chk($sformatf("tbl%0d_level", i),  32'(s_level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_rdata", i),  32'(s_rdata), 32'(tbl[i].rdata));
            chk($sformatf("tbl%0d_rvalid", i), 32'(s_rv),    32'(tbl[i].rv));
            chk($sformatf("tbl%0d_full", i),   32'(s_full),  32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i),  32'(s_empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_afull", i),  32'(s_af),    32'(tbl[i].af));
            chk($sformatf("tbl%0d_aempty", i), 32'(s_ae),    32'(tbl[i].ae));
            chk($sformatf("tbl%0d_ovf", i),    32'(s_ovf),   32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i),    32'(s_unf),   32'(tbl[i].unf));
        end

        // wrap-around: pointers pass through 7->0 several times
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 16'(16'h0100 + 2 * k), 1'b0);
            step(1'b0, 1'b1, 16'(16'h0101 + 2 * k), 1'b0);
            step(1'b0, 1'b0, 16'h0000, 1'b1);
            chk("wrap_first", 32'(s_rdata), 32'(16'h0100 + 2 * k));
            step(1'b0, 1'b0, 16'h0000, 1'b1);
            chk("wrap_second", 32'(s_rdata), 32'(16'h0101 + 2 * k));
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(39) == 0, $urandom_range(9) < 6, 16'($urandom),
                 $urandom_range(1) == 1);
        end

        // FWFT presentation without a read, then acknowledge
        step(1'b1, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 1'b0);
        chk("fwft_rv_after_write", 32'(f_rv), 32'd1);
        chk("fwft_data_no_read", 32'(f_rdata), 32'h1234);
        step(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("fwft_data_held", 32'(f_rdata), 32'h1234);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("fwft_empty_after_ack", 32'(f_empty), 32'd1);
        chk("fwft_rv_after_ack", 32'(f_rv), 32'd0);

        // asynchronous reset mid-operation at level 3
        step(1'b0, 1'b1, 16'h0011, 1'b0);
        step(1'b0, 1'b1, 16'h0022, 1'b0);
        step(1'b0, 1'b1, 16'h0033, 1'b0);
        chk("pre_rst_level", 32'(s_level), 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_rst_rdata", 32'(s_rdata), 32'd0);
        chk("async_rst_level", 32'(s_level), 32'd0);
        #2;
        resetn = 1'b1;
        step(1'b0, 1'b1, 16'h00AA, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        chk("post_rst_read", 32'(s_rdata), 32'h00AA);
        step(1'b0, 1'b0, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
